// File: rtl/async_hs_pkg.sv
// ============================================================================
// Module      : async_hs_pkg
// Description : Shared types/constants for the async-to-sync receive endpoint.
//               ASYNC_RX_SYNC3_EN selects a 3-flop req synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_hs_pkg;

   typedef logic phase_t;

`ifdef ASYNC_RX_SYNC3_EN
   localparam int REQ_SYNC_STAGES = 3;
`else
   localparam int REQ_SYNC_STAGES = 2;
`endif

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/req_synchronizer.sv
// ============================================================================
// Module      : req_synchronizer
// Description : Multi-flop level synchronizer for the two-phase request line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/async_to_sync_rx.sv
// ============================================================================
// Module      : async_to_sync_rx
// Description : Two-phase bundled-data receiver feeding a FWFT valid/ready FIFO.
//               Build option ASYNC_RX_SYNC3_EN adds a third synchronizer flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_to_sync_rx
   import async_hs_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_in_i,
   input  logic [DATA_W-1:0]          data_in_i,
   output logic                       ack_in_o,
   output logic [DATA_W-1:0]          data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int              PW      = ptr_width(DEPTH);
   localparam int              CW      = $clog2(DEPTH+1);
   localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

   phase_t              w_req_s;
   phase_t              r_ack;
   logic                w_pending;
   logic                w_push;
   logic                w_pop;
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   req_synchronizer #(
      .STAGES (REQ_SYNC_STAGES)
   ) u_req_sync (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_d   (req_in_i),
      .o_q   (w_req_s)
   );

   // Toggling ack on the capture edge clears pending next cycle: one capture per event.
   assign w_pending = (w_req_s != r_ack);
   assign w_pop     = valid_o && ready_i;
   assign w_push    = w_pending && ((r_count < C_DEPTH) || w_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ack    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= data_in_i;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
            r_ack           <= ~r_ack;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign ack_in_o = r_ack;
   assign valid_o  = (r_count != '0);
   assign data_o   = r_mem[r_rd_ptr];
   assign count_o  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_async_to_sync_rx.sv
// ============================================================================
// Module      : tb_async_to_sync_rx
// Description : Directed self-checking bench for async_to_sync_rx.
//               Honors ASYNC_RX_SYNC3_EN for the req-to-ack latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_to_sync_rx;

`ifdef ASYNC_RX_SYNC3_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] din;
   logic        ack;
   logic [31:0] dout;
   logic        valid;
   logic        ready;
   logic [2:0]  cnt;

   int n_tests = 0;
   int n_fail  = 0;

   async_to_sync_rx #(.DATA_W(32), .DEPTH(4)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_in_i  (req),
      .data_in_i (din),
      .ack_in_o  (ack),
      .data_o    (dout),
      .valid_o   (valid),
      .ready_i   (ready),
      .count_o   (cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one event and wait (bounded) for its ack toggle.
   task automatic send(input logic [31:0] d, input string tag);
      logic prev;
      logic e;
      int   k;
      prev = ack;
      e    = ~prev;
      din  = d;
      req  = ~req;
      k    = 0;
      while (ack === prev && k < 20) begin
         step();
         k++;
      end
      chk(tag, {31'b0, ack}, {31'b0, e});
   endtask

   initial begin
      logic        prev;
      logic        e;
      int          k;
      int          toggles;
      logic [2:0]  maxcnt;

      rst = 1'b1; req = 1'b0; din = '0; ready = 1'b0;

      // reset, with a req toggle arriving while reset is held
      step();
      req = 1'b1;
      step();
      step();
      chk("rst_ack",   {31'b0, ack},   32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_count", {29'b0, cnt},   32'd0);
      rst = 1'b0;
      for (int i = 1; i < LAT; i++) begin
         step();
         chk("rst_ack_early", {31'b0, ack}, 32'd0);
      end
      step();
      chk("rst_ack_lat", {31'b0, ack}, 32'd1);
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("rst_drain_cnt", {29'b0, cnt}, 32'd0);

      // single transfer
      din = 32'hDEADBEEF;
      req = ~req;
      for (int i = 1; i < LAT; i++) begin
         step();
         chk("single_ack_early", {31'b0, ack},   32'd1);
         chk("single_valid_early", {31'b0, valid}, 32'd0);
      end
      step();
      chk("single_ack", {31'b0, ack}, 32'd0);
      step();
      chk("single_valid", {31'b0, valid}, 32'd1);
      chk("single_data",  dout,           32'hDEADBEEF);
      chk("single_cnt",   {29'b0, cnt},   32'd1);
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("single_pop_valid", {31'b0, valid}, 32'd0);
      chk("single_pop_cnt",   {29'b0, cnt},   32'd0);

      // fill and stall
      for (int i = 1; i <= 4; i++) send(32'(i), "fill_ack");
      chk("fill_cnt", {29'b0, cnt}, 32'd4);
      prev = ack;
      din  = 32'd5;
      req  = ~req;
      repeat (8) step();
      chk("full_ack_withheld", {31'b0, ack}, {31'b0, prev});
      chk("full_cnt",          {29'b0, cnt}, 32'd4);
      chk("full_head",         dout,         32'd1);

      // full with simultaneous push and pop
      e     = ~prev;
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("pushpop_ack",  {31'b0, ack}, {31'b0, e});
      chk("pushpop_cnt",  {29'b0, cnt}, 32'd4);
      chk("pushpop_head", dout,         32'd2);
      ready = 1'b1;
      for (int v = 2; v <= 5; v++) begin
         chk("drain_data", dout, 32'(v));
         step();
      end
      ready = 1'b0;
      chk("drain_valid", {31'b0, valid}, 32'd0);
      chk("drain_cnt",   {29'b0, cnt},   32'd0);

      // pointer wrap with continuous ready
      ready   = 1'b1;
      toggles = 0;
      maxcnt  = '0;
      for (int i = 0; i < 10; i++) begin
         prev = ack;
         din  = 32'hA000_0000 + 32'(i);
         req  = ~req;
         k    = 0;
         while (ack === prev && k < 20) begin
            step();
            k++;
            if (cnt > maxcnt) maxcnt = cnt;
         end
         if (ack !== prev) toggles++;
         chk("wrap_data", dout, 32'hA000_0000 + 32'(i));
         step();
         if (cnt > maxcnt) maxcnt = cnt;
      end
      ready = 1'b0;
      chk("wrap_toggles", 32'(toggles), 32'd10);
      chk("wrap_maxcnt",  {29'b0, maxcnt}, 32'd1);
      chk("wrap_ack_level", {31'b0, ack}, 32'd1);

      // reset mid-operation discards the in-flight event
      din = 32'd77;
      req = ~req;
      step();
      rst = 1'b1;
      req = 1'b0;
      #1;
      chk("midrst_ack", {31'b0, ack}, 32'd0);
      step();
      rst = 1'b0;
      repeat (LAT + 2) step();
      chk("midrst_ack_after", {31'b0, ack},   32'd0);
      chk("midrst_valid",     {31'b0, valid}, 32'd0);
      chk("midrst_cnt",       {29'b0, cnt},   32'd0);

      // recovery after reset
      send(32'd55, "recover_ack");
      chk("recover_data", dout, 32'd55);
      chk("recover_cnt",  {29'b0, cnt}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/async_to_sync_rx.md
Name: async_to_sync_rx

Overview:
- Synchronous receive endpoint for the two-phase bundled-data req/ack channel driven by the asynchronous controller pipeline.
- Consumes events from the last async stage, synchronizes req into the clock domain, captures the bundled data into a small FIFO and returns ack.
- Presents the data to clocked logic through a valid/ready interface.
- Sits at the async-to-sync boundary in rtl/sync.

Parameters:
DATA_W, 32, width of the bundled data word
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
req_in_i  input  1  two-phase request from the async sender; each transition is one event; asynchronous to clk_i
data_in_i  input  DATA_W  bundled data; sender holds it stable from its req transition until the matching ack transition
ack_in_o  output  1  two-phase acknowledge; one toggle per captured event
data_o  output  DATA_W  FIFO head word (first-word fall-through)
valid_o  output  1  FIFO non-empty
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
count_o  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): ack_in_o=0, valid_o=0, data_o=0, count_o=0; synchronizer flops=0; pointers=0. Expected req phase after reset is 0.
- req_in_i passes through a 2-flop synchronizer to produce req_s.
- pending = (req_s != ack_in_o).
- push = pending && (count < DEPTH || pop).
- pop = valid_o && ready_i.
- On push: data_in_i is written at wr_ptr and ack_in_o toggles on the same edge, so pending clears the next cycle. This guarantees exactly one capture per event.
- Bundling safety: data_in_i is sampled no earlier than 2 edges after the req transition. The sender's data setup is covered by the synchronizer delay; no extra data synchronization is used.
- Latency: req transition to ack toggle is 3 rising edges when not full. Write to valid_o is 1 edge. The head is visible combinationally from the registered RAM and pointer.
- FIFO is a circular buffer with pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH. count is tracked separately (0..DEPTH).
- Full (count=DEPTH) without pop: no push, ack withheld, event stays pending. The sender stalls naturally and no data is lost.
- Full with pop in the same cycle: push is allowed and count stays at DEPTH.
- Empty with push: count goes 0 -> 1 and valid_o rises next edge. No same-cycle bypass.
- Empty: valid_o=0; data_o is don't-care (benches must not check it).
- Push and pop in the same cycle at any occupancy: count unchanged, both pointers advance.
- Only one event can be pending at a time: the protocol forbids a second req toggle before ack toggles.
- Reset mid-operation: any in-flight event and all FIFO contents are discarded and ack returns to 0. The sender must be reset in the same reset domain.

Optional Feature:
- Macro: ASYNC_RX_SYNC3_EN.
- Defined: the req synchronizer has 3 flops, and req-to-ack latency becomes 4 edges. Use for high-MTBF targets.
- Undefined: 2 flops, behaviour as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package async_hs_pkg:
  - typedef phase_t (1-bit two-phase level)
  - localparam REQ_SYNC_STAGES (2, or 3 under the macro)
  - function for FIFO pointer width
- One sub-module, req_synchronizer:
  - parameterized by stage count
  - async active-high reset
  - flops marked for CDC tooling
- FIFO storage and control stay inline.

Test Plan:
- Reset: hold rst_i 3 cycles, release -> ack_in_o=0, valid_o=0, count_o=0. Toggling req_in_i 0->1 during reset -> no ack until 3 edges after release.
- Single transfer: data_in_i=32'hDEADBEEF, req_in_i 0->1 -> ack_in_o 0->1 on the 3rd edge, valid_o=1 one edge later, data_o=32'hDEADBEEF. ready_i=1 one cycle -> valid_o=0, count_o=0.
- Fill and stall: ready_i=0, DEPTH=4, five events with data 1..5 -> four ack toggles, count_o=4, 5th ack withheld. Raise ready_i for one cycle -> 5th ack toggles, count_o stays 4. Drain -> order 1,2,3,4,5.
- Full with simultaneous push/pop: count_o=4, pending event, ready_i=1 -> push and pop on the same edge, count_o=4, ack toggles, no entry lost or duplicated.
- Pointer wrap: 10 events with ready_i=1 throughout -> data_o sequence matches input in order, count_o never exceeds 1, ack toggles 10 times.
- Mid-operation reset and macro build: toggle req, assert rst_i after 1 edge -> ack_in_o stays 0 and valid_o stays 0. With ASYNC_RX_SYNC3_EN defined, repeat the single-transfer case -> ack toggles on the 4th edge.
